// File: rtl/melody_sequencer.sv
// melody_sequencer
// Walks an eight-step melody table and drives a square-wave tone generator.
// Each step sounds for its duration minus a short articulation gap, then
// stays silent for the gap. The sequence can stop, finish or loop.
// All outputs are registered. The state machine is one always_ff block.
//
// gap_cycles must be at least 1 and less than beat_cycles. The NOTE phase
// of a one-beat step is then always at least one cycle long.

module melody_sequencer #(
  parameter int clock_frequency = 12000000,
  parameter int beat_cycles     = clock_frequency / 8,
  parameter int gap_cycles      = clock_frequency / 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  output logic        tone_enable,
  output logic [15:0] half_period,
  output logic [2:0]  step,
  output logic        busy,
  output logic        done
);

  // The step counter must hold a full seven-beat step without wrapping.
  localparam int count_width = $clog2(7 * beat_cycles + 1);

  localparam logic [count_width-1:0] count_one  = count_width'(1);
  localparam logic [count_width-1:0] beat_count = count_width'(beat_cycles);
  localparam logic [count_width-1:0] gap_count  = count_width'(gap_cycles);

  // Note codes used in the melody table.
  localparam logic [2:0] note_rest = 3'd0;
  localparam logic [2:0] note_c4   = 3'd1;
  localparam logic [2:0] note_d4   = 3'd2;
  localparam logic [2:0] note_e4   = 3'd3;
  localparam logic [2:0] note_f4   = 3'd4;
  localparam logic [2:0] note_g4   = 3'd5;
  localparam logic [2:0] note_a4   = 3'd6;
  localparam logic [2:0] note_b4   = 3'd7;

  // Each half-period is clock_frequency*100 / (2 * pitch_in_centihertz),
  // truncated. The arithmetic is done in 64 bits so that it cannot
  // overflow at any realistic clock frequency.
  localparam longint unsigned clock_x100 = 64'(clock_frequency) * 64'd100;

  localparam logic [15:0] half_period_c4 = 16'(clock_x100 / 64'd52326);  // 261.63 Hz
  localparam logic [15:0] half_period_d4 = 16'(clock_x100 / 64'd58732);  // 293.66 Hz
  localparam logic [15:0] half_period_e4 = 16'(clock_x100 / 64'd65926);  // 329.63 Hz
  localparam logic [15:0] half_period_f4 = 16'(clock_x100 / 64'd69846);  // 349.23 Hz
  localparam logic [15:0] half_period_g4 = 16'(clock_x100 / 64'd78400);  // 392.00 Hz
  localparam logic [15:0] half_period_a4 = 16'(clock_x100 / 64'd88000);  // 440.00 Hz
  localparam logic [15:0] half_period_b4 = 16'(clock_x100 / 64'd98776);  // 493.88 Hz

  typedef enum logic [1:0] {
    state_idle,
    state_note,
    state_gap
  } state_t;

  // Melody table: {note code, duration in beats}.
  function automatic logic [5:0] melody_entry(input logic [2:0] index);
    logic [5:0] entry;
    case (index)
      3'd0:    entry = {note_c4,   3'd2};
      3'd1:    entry = {note_e4,   3'd2};
      3'd2:    entry = {note_g4,   3'd2};
      3'd3:    entry = {note_rest, 3'd2};
      3'd4:    entry = {note_g4,   3'd1};
      3'd5:    entry = {note_e4,   3'd1};
      3'd6:    entry = {note_c4,   3'd4};
      default: entry = {note_rest, 3'd2};
    endcase
    return entry;
  endfunction

  // Maps a note code to its half-period. Rests return 0, but the caller
  // never loads a rest into half_period.
  function automatic logic [15:0] note_half_period(input logic [2:0] code);
    logic [15:0] value;
    case (code)
      note_c4: value = half_period_c4;
      note_d4: value = half_period_d4;
      note_e4: value = half_period_e4;
      note_f4: value = half_period_f4;
      note_g4: value = half_period_g4;
      note_a4: value = half_period_a4;
      note_b4: value = half_period_b4;
      default: value = 16'd0;
    endcase
    return value;
  endfunction

  // Returns the step length in cycles. A duration of 0 counts as one beat.
  function automatic logic [count_width-1:0] step_cycles(input logic [2:0] duration);
    logic [2:0] beats;
    beats = (duration == 3'd0) ? 3'd1 : duration;
    return count_width'(beats) * beat_count;
  endfunction

  state_t                 state_reg;
  logic [count_width-1:0] count_reg;

  logic [2:0]             step_next;
  logic [5:0]             entry_current;
  logic [5:0]             entry_next;
  logic [5:0]             entry_first;
  logic [count_width-1:0] step_length;
  logic [count_width-1:0] note_length;
  logic                   note_last;
  logic                   gap_last;
  logic                   next_pitched;
  logic                   first_pitched;

  // Decode the table for the current step, the following step and step 0.
  // The following step and step 0 are needed because tone_enable and
  // half_period are loaded at the same edge that enters the new step.
  always_comb begin
    step_next     = step + 3'd1;
    entry_current = melody_entry(step);
    entry_next    = melody_entry(step_next);
    entry_first   = melody_entry(3'd0);
    step_length   = step_cycles(entry_current[2:0]);
    note_length   = step_length - gap_count;
    note_last     = (count_reg == note_length - count_one);
    gap_last      = (count_reg == step_length - count_one);
    next_pitched  = (entry_next[5:3] != note_rest);
    first_pitched = (entry_first[5:3] != note_rest);
  end

  // Sequencer state machine. The count runs from 0 to step_length-1
  // across the NOTE and GAP phases of each step. All outputs are
  // registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= state_idle;
      count_reg   <= '0;
      tone_enable <= 1'b0;
      half_period <= 16'd0;
      step        <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (stop) begin
      // An abort silences the output at once. half_period keeps its last
      // value, and no done pulse is produced.
      state_reg   <= state_idle;
      count_reg   <= '0;
      tone_enable <= 1'b0;
      step        <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        state_idle: begin
          if (start) begin
            state_reg   <= state_note;
            count_reg   <= '0;
            step        <= 3'd0;
            busy        <= 1'b1;
            tone_enable <= first_pitched;
            if (first_pitched) begin
              half_period <= note_half_period(entry_first[5:3]);
            end
          end
        end

        state_note: begin
          count_reg <= count_reg + count_one;
          if (note_last) begin
            state_reg   <= state_gap;
            tone_enable <= 1'b0;
          end
        end

        state_gap: begin
          if (!gap_last) begin
            count_reg <= count_reg + count_one;
          end else begin
            count_reg <= '0;
            // step_next wraps from 7 to 0, so looping needs no special case.
            if (step != 3'd7 || loop) begin
              state_reg   <= state_note;
              step        <= step_next;
              tone_enable <= next_pitched;
              if (next_pitched) begin
                half_period <= note_half_period(entry_next[5:3]);
              end
            end else begin
              state_reg <= state_idle;
              step      <= 3'd0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        default: begin
          state_reg   <= state_idle;
          count_reg   <= '0;
          tone_enable <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Controller that drives the team's square-wave tone generator through a fixed eight-step melody held in an internal table. For each step it supplies the half-period in clock cycles and a tone enable. It also times the note duration and inserts a short silent gap between notes for articulation. It sits between the board buttons (start/stop/loop) and the tone generator, which toggles its output every half_period cycles while tone_enable is high.

Parameters:
clock_frequency, 12000000, system clock in Hz; used to derive the half-period table values
beat_cycles, clock_frequency/8, clock cycles per duration unit (125 ms at 12 MHz)
gap_cycles, clock_frequency/100, silent cycles at the end of every step (10 ms); must be less than beat_cycles

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins playback from step 0 when idle
stop  input  1  one-cycle pulse; aborts playback
loop  input  1  level; when high, playback restarts at step 0 after step 7
tone_enable  output  1  high while the tone generator must sound
half_period  output  16  tone generator half-period in clock cycles
step  output  3  index of the current melody step
busy  output  1  high from the first playback cycle until return to idle
done  output  1  one-cycle pulse on natural (non-looped) completion

Behaviour:
- All outputs are registered. Reset values: tone_enable 0, half_period 0, step 0, busy 0, done 0; the state machine goes to IDLE.
- Table entries carry a note code (3 bits) and a duration (3 bits, in beats; 0 is treated as 1).
- Note codes and half_period values, computed as clock_frequency*100/(2*freq_mul_100) with truncation (values shown for 12 MHz):
  - 1=C4 22933
  - 2=D4 20431
  - 3=E4 18202
  - 4=F4 17180
  - 5=G4 15306
  - 6=A4 13636
  - 7=B4 12148
  - 0=rest
- Melody table (code, duration): 0:(C4,2) 1:(E4,2) 2:(G4,2) 3:(rest,2) 4:(G4,1) 5:(E4,1) 6:(C4,4) 7:(rest,2).
- States: IDLE, NOTE, GAP.
  - IDLE: start=1 and stop=0 -> NOTE with step=0, duration counter cleared. Entry outputs appear the next cycle: busy=1, and tone_enable=1 unless the step is a rest.
  - NOTE: lasts exactly dur*beat_cycles - gap_cycles cycles, then -> GAP.
  - GAP: lasts exactly gap_cycles cycles with tone_enable=0, then advances.
- Advance rules after GAP:
  - step<7 -> NOTE with step+1, no dead cycle.
  - step=7 and loop=1 -> NOTE with step 0.
  - step=7 and loop=0 -> IDLE with busy=0 and done=1 for one cycle.
  - loop is sampled only on the last GAP cycle of step 7.
- Total step length is dur*beat_cycles cycles.
- Rest steps: tone_enable=0 in both NOTE and GAP.
- half_period updates on entry to a pitched NOTE and holds its last value through gaps, rests and IDLE.
- stop=1 in any state -> IDLE next cycle: tone_enable=0, busy=0, step=0, no done pulse.
- stop has priority over a simultaneous start.
- start while busy is ignored.
- reset mid-playback has the same effect as the reset values above, and also clears half_period.
- The duration counter is wide enough for 7*beat_cycles and does not wrap within a step.

Test Plan:
All scenarios use the simulation override beat_cycles=10, gap_cycles=2.
1. Reset, then start pulse at cycle T -> at T+1: busy=1, step=0, tone_enable=1, half_period=22933. tone_enable stays high for 18 cycles, then low for 2. At T+21: step=1, half_period=18202.
2. Full playback with loop=0 -> step sequence 0..7 with cumulative length 160 cycles. done=1 for exactly one cycle at T+161, then busy=0. tone_enable stays 0 throughout steps 3 and 7. half_period=22933 holds after completion.
3. loop=1 throughout -> after step 7, step returns to 0 with no idle cycle. done is never asserted and busy stays 1.
4. stop pulse midway through step 2 -> next cycle: tone_enable=0, busy=0, step=0, done=0. A subsequent start restarts at step 0.
5. start and stop asserted in the same cycle while IDLE -> remains IDLE with busy=0. A start pulse issued during step 4 -> no effect on the step timing.
6. reset asserted during step 5 NOTE -> next cycle all outputs are 0 (half_period=0) in IDLE. start afterwards reproduces scenario 1 timing exactly.
